motor_mux_ctrl: RTL
===================

# motor_mux_ctrl

Sequencer that owns the configuration inputs of one `motor_mux` output channel: `mux_select`, `enable_step`, `invert_dir`, `enable_es_abort`, and a filtered `es_abort`. Software or the motion core writes a new channel configuration. The block applies it glitch-free: it blanks step, waits for the outgoing step pulse to end, switches routing, then holds a direction-setup guard before re-enabling step. It also debounces the raw endstop before it reaches the mux abort logic. One instance per physical driver output.

## Interface
- `DIR_SETUP`, default 50: step-blanked cycles after a routing or effective-direction change. 0 disables the guard.
- `DRAIN_TIMEOUT`, default 1000: maximum cycles spent waiting for the old step to go low.
- `ES_FILTER`, default 16: consecutive high cycles required to qualify the endstop. 1 or more.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `steps` in 8: step lines of all generators, observed only.
- `dirs` in 8: dir lines of all generators, observed only.
- `cfg_wr` in 1: write strobe, accepted only when `cfg_busy`=0.
- `cfg_select` in 3: new source generator index.
- `cfg_enable_step` in 1: new step enable.
- `cfg_invert_dir` in 1: new dir inversion.
- `cfg_enable_es_abort` in 1: new endstop-abort enable.
- `es_raw` in 1: raw endstop input, already synchronised upstream.
- `es_clear` in 1: clears `es_tripped`.
- `mux_select` out 3: to mux.
- `enable_step` out 1: to mux.
- `invert_dir` out 1: to mux.
- `enable_es_abort` out 1: to mux.
- `es_abort` out 1: filtered endstop, to mux.
- `cfg_busy` out 1: reconfiguration in progress.
- `cfg_done` out 1: one-cycle pulse when the new configuration is live.
- `drain_timeout` out 1: one-cycle pulse when drain was forced.
- `es_tripped` out 1: sticky; set when `es_abort` and `enable_es_abort` are both high.

## Operation
- Reset values: all outputs 0. State RUN. Shadow and counters cleared. Any pending configuration is discarded; reset overrides everything, including mid-sequence.
- States: RUN, DRAIN, SETUP.
- RUN: outputs reflect the active registers. `cfg_wr` latches all `cfg_*` into a shadow, then goes to DRAIN.
- DRAIN: `enable_step`=0 and `cfg_busy`=1.
  - Exit when `steps[mux_select]`=0, or when the drain counter reaches `DRAIN_TIMEOUT`; in the timeout case pulse `drain_timeout`.
  - On exit, load the shadow into the active registers.
  - Compute `chg` = (select changed) or (`dirs[old]^old_inv` differs from `dirs[new]^new_inv`).
  - If `chg` and `DIR_SETUP`>0, go to SETUP; otherwise go to RUN.
- SETUP: new `mux_select`, `invert_dir` and `enable_es_abort` are visible; `enable_step` stays 0. Lasts exactly `DIR_SETUP` cycles, then RUN.
- Entry to RUN from a reconfiguration: `enable_step` takes its new value, `cfg_busy`=0, `cfg_done`=1 for that single cycle.
- `cfg_wr` while `cfg_busy`=1: ignored. No queue, no error flag.
- Endstop filter:
  - Counter increments while `es_raw`=1 and saturates at `ES_FILTER`; it clears to 0 on any `es_raw`=0 cycle.
  - `es_abort`=1 while counter = `ES_FILTER`; it drops the cycle after `es_raw` falls.
  - Filter runs in every state.
- `es_tripped`: set when `es_abort & enable_es_abort`; cleared by `es_clear`. If set and clear happen in the same cycle, set wins.

## Timing
- `cfg_wr` accepted at edge T: `cfg_busy`=1 and `enable_step`=0 from T+1.
- DRAIN checks its exit condition from T+1. If the exit condition is true at T+1, the new routing is visible at T+2.
- With guard: `enable_step` is re-asserted and `cfg_done` pulses at T+2+`DIR_SETUP`. Without guard: both at T+2.
- Drain timeout: forced exit in the cycle the counter equals `DRAIN_TIMEOUT`. `drain_timeout` pulses in the same cycle as the register load.
- Endstop: `es_raw` rises at R; `es_abort` rises at R+`ES_FILTER`.
- Counter widths: `$clog2(max+1)` of the respective parameter. No wrap; counters saturate or are reset on state entry.

## Structure
- Shared package `motor_pkg`: state enum (RUN/DRAIN/SETUP), and a channel-config struct {select[2:0], en_step, inv_dir, en_es}, reusable by the register file.
- One sub-module is natural: `es_filter` (debounce counter plus qualified output). It is parameterised by `ES_FILTER`.

## Test plan
- Reset, then write sel=2, en_step=1, inv=0, with `steps`=0 and `dirs`=0. Required: `mux_select`=2 at T+2, `enable_step`=1 and `cfg_done` at T+52.
- `steps[0]` high for 10 cycles when sel 0→0 is written with the same dir. Required: 10 cycles in DRAIN; no SETUP; `cfg_done` on the cycle after `steps[0]` falls.
- `steps[sel]` stuck high with `DRAIN_TIMEOUT`=1000. Required: `drain_timeout` pulse after 1000 DRAIN cycles, then normal SETUP and RUN.
- `es_raw` pulses of 15 and 16 cycles with `enable_es_abort`=1. Required: first pulse gives no `es_abort`; second gives a 1-cycle `es_abort` and sets `es_tripped`. `es_clear` in the same cycle as a trip leaves `es_tripped`=1.
- Second `cfg_wr` issued during SETUP. Required: ignored; the final configuration equals the first write.
- `reset` asserted mid-SETUP. Required: all outputs 0 next cycle; a `cfg_wr` on the cycle after reset deasserts is accepted.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types for the motor output channel: sequencer states, channel
// configuration record and counter sizing helpers.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SETUP = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] select;
        logic       en_step;
        logic       inv_dir;
        logic       en_es;
    } chan_cfg_t;

    // Width able to hold max_val; a zero-cycle parameter still gets a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // Direction as seen by the driver once routing and inversion are applied.
    function automatic logic eff_dir(input logic [7:0] dir_lines, input chan_cfg_t cfg);
        return dir_lines[cfg.select] ^ cfg.inv_dir;
    endfunction

endpackage

// File: rtl/motor_mux_ctrl_es_filter.sv
// Endstop debounce: qualifies es_raw after ES_FILTER consecutive high cycles
// and drops the qualified level the cycle after es_raw falls.
module es_filter
    import motor_pkg::*;
#(
    parameter int unsigned ES_FILTER = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic es_raw_i,
    output logic es_abort_o
);

    localparam int unsigned      CNT_W   = cnt_width(ES_FILTER);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ES_FILTER);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!es_raw_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign es_abort_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/motor_mux_ctrl.sv
// Reconfiguration sequencer for one motor_mux output channel: blanks step,
// drains the outgoing pulse, switches routing, then guards direction setup.
module motor_mux_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned DIR_SETUP     = 50,
    parameter int unsigned DRAIN_TIMEOUT = 1000,
    parameter int unsigned ES_FILTER     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] steps,
    input  logic [7:0] dirs,
    input  logic       cfg_wr,
    input  logic [2:0] cfg_select,
    input  logic       cfg_enable_step,
    input  logic       cfg_invert_dir,
    input  logic       cfg_enable_es_abort,
    input  logic       es_raw,
    input  logic       es_clear,
    output logic [2:0] mux_select,
    output logic       enable_step,
    output logic       invert_dir,
    output logic       enable_es_abort,
    output logic       es_abort,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       drain_timeout,
    output logic       es_tripped
);

    localparam int unsigned DRAIN_W = cnt_width(DRAIN_TIMEOUT);
    localparam int unsigned SETUP_W = cnt_width(DIR_SETUP);

    state_e             state_q,     state_d;
    chan_cfg_t          active_q,    active_d;
    chan_cfg_t          shadow_q,    shadow_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
    logic               done_q,      done_d;
    logic               timeout_q,   timeout_d;
    logic               tripped_q,   tripped_d;

    logic old_step;
    logic drain_expired;
    logic setup_last;
    logic route_chg;

    es_filter #(
        .ES_FILTER (ES_FILTER)
    ) u_es_filter (
        .clk        (clk),
        .reset      (reset),
        .es_raw_i   (es_raw),
        .es_abort_o (es_abort)
    );

    // Counters count cycles already spent, so "+1" names the current cycle.
    always_comb begin
        old_step      = steps[active_q.select];
        drain_expired = (32'(drain_cnt_q) + 32'd1) >= DRAIN_TIMEOUT;
        setup_last    = (32'(setup_cnt_q) + 32'd1) >= DIR_SETUP;
        route_chg     = (shadow_q.select != active_q.select) ||
                        (eff_dir(dirs, shadow_q) != eff_dir(dirs, active_q));
    end

    // NOTE: every always_comb target gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        shadow_d    = shadow_q;
        drain_cnt_d = drain_cnt_q;
        setup_cnt_d = setup_cnt_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (cfg_wr) begin
                    shadow_d.select  = cfg_select;
                    shadow_d.en_step = cfg_enable_step;
                    shadow_d.inv_dir = cfg_invert_dir;
                    shadow_d.en_es   = cfg_enable_es_abort;
                    drain_cnt_d      = '0;
                    state_d          = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!old_step || drain_expired) begin
                    active_d  = shadow_q;
                    timeout_d = old_step;
                    if (route_chg && (DIR_SETUP > 0)) begin
                        setup_cnt_d = '0;
                        state_d     = ST_SETUP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_SETUP: begin
                if (setup_last) begin
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A trip in the same cycle as a clear must survive.
    assign tripped_d = (es_abort & active_q.en_es) | (tripped_q & ~es_clear);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            active_q    <= '0;
            shadow_q    <= '0;
            drain_cnt_q <= '0;
            setup_cnt_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            tripped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            drain_cnt_q <= drain_cnt_d;
            setup_cnt_q <= setup_cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            tripped_q   <= tripped_d;
        end
    end

    assign mux_select      = active_q.select;
    assign invert_dir      = active_q.inv_dir;
    assign enable_es_abort = active_q.en_es;
    assign enable_step     = active_q.en_step && (state_q == ST_RUN);
    assign cfg_busy        = (state_q != ST_RUN);
    assign cfg_done        = done_q;
    assign drain_timeout   = timeout_q;
    assign es_tripped      = tripped_q;

endmodule
